// File: rtl/bcd_seg7_scan.sv
// bcd_seg7_scan: multiplexed common-anode 7-segment driver for a packed BCD word.
// Define SEG7_BLANK_LZ_EN to blank leading-zero digits.
module bcd_seg7_scan #(
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] snap;
    logic [CW-1:0]       count;
    logic [IW-1:0]       idx;
    logic                tick;
    logic [3:0]          nib;
    logic                blank_lz;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign tick = count == CW'(REFRESH_DIV - 1);
    assign nib  = snap[4*idx +: 4];

`ifdef SEG7_BLANK_LZ_EN
    // lz[k] is set when nibble k and every higher nibble are zero
    logic [DIGITS:0] lz;
    always_comb begin
        lz = '1;
        for (int k = DIGITS - 1; k >= 0; k--)
            lz[k] = lz[k+1] && snap[4*k +: 4] == 4'd0;
        blank_lz = idx != '0 && lz[idx];
    end
`else
    assign blank_lz = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap  <= '0;
            count <= '0;
            idx   <= '0;
            an    <= '1;
            seg   <= 7'b1111111;
        end else begin
            if (load)
                snap <= bcd_in;
            count <= tick ? '0 : count + 1'b1;
            if (tick)
                idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
            an  <= tick ? '1 : ~(DIGITS'(1) << idx);
            seg <= tick || blank_lz ? 7'b1111111 : decode(nib);
        end
    end
endmodule

// File: tb/tb_bcd_seg7_scan.sv
// tb_bcd_seg7_scan: randomized check of the scan driver against a cycle-position model.
module tb_bcd_seg7_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [11:0] bcd_in = '0;
    logic [6:0]  seg;
    logic [2:0]  an;
    int          checks = 0;
    int          failures = 0;
    int          n = 0;
    logic [11:0] snap_m = '0;

    bcd_seg7_scan #(.DIGITS(3), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b at n=%0d t=%0t", tag, got, exp, n, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return d < 10 ? t[d] : 7'h3f;
    endfunction

    // one clock: outputs after edge n depend on position n within the 12-edge scan frame
    task automatic cyc(input logic l, input logic [11:0] d);
        int c, i, v;
        logic [2:0] ea;
        logic [6:0] es;
        load = l;
        bcd_in = d;
        @(posedge clk);
        c = n % 4;
        i = (n / 4) % 3;
        v = (int'(snap_m) >> (4 * i)) & 15;
        ea = c == 3 ? 3'b111 : ~(3'b001 << i);
        es = c == 3 ? 7'h7f : seg_of(v);
`ifdef SEG7_BLANK_LZ_EN
        if (c != 3 && i > 0 && (int'(snap_m) >> (4 * i)) == 0) es = 7'h7f;
`endif
        if (l) snap_m = d;
        n++;
        #2;
        check("an", {4'b0, an}, {4'b0, ea});
        check("seg", seg, es);
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_an", {4'b0, an}, 7'b0000111);
        check("rst_seg", seg, 7'b1111111);
        rst = 1'b0;
        cyc(1'b0, 12'h000);
        check("first_lit_an", {4'b0, an}, 7'b0000110);
        check("first_lit_seg", seg, 7'b1000000);
        for (int k = 0; k < 10; k++) cyc(1'b0, 12'h000);
        cyc(1'b1, 12'h255);
        for (int k = 0; k < 26; k++) cyc(1'b0, 12'h000);
        cyc(1'b1, 12'h1A3);
        for (int k = 0; k < 26; k++) cyc(1'b0, 12'h000);
        cyc(1'b1, 12'h007);
        for (int k = 0; k < 26; k++) cyc(1'b0, 12'h000);
        while (n % 12 != 3) cyc(1'b0, 12'h000);
        cyc(1'b1, 12'h999);
        check("coinc_blank", {4'b0, an}, 7'b0000111);
        cyc(1'b0, 12'h000);
        check("coinc_an", {4'b0, an}, 7'b0000101);
        check("coinc_seg", seg, 7'b0010000);
        for (int k = 0; k < 400; k++)
            cyc($urandom_range(7) == 0, 12'($urandom));
        cyc(1'b1, 12'h840);
        cyc(1'b1, 12'hF00);
        for (int k = 0; k < 24; k++) cyc(1'b0, 12'h000);
        while (n % 12 != 9) cyc(1'b0, 12'h000);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_an", {4'b0, an}, 7'b0000111);
        check("mid_rst_seg", seg, 7'b1111111);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        snap_m = '0;
        for (int k = 0; k < 24; k++) cyc(1'b0, 12'h000);
        for (int k = 0; k < 300; k++)
            cyc($urandom_range(5) == 0, {$urandom_range(1) ? 4'h0 : 4'($urandom), 4'($urandom), 4'($urandom)});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
